// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT pipeline defaults, sample/frame types and bit-reversal helper
package fft_pkg;

    localparam int SAMPLES = 8;
    localparam int WIDTH   = 4;
    localparam int ADDR_W  = $clog2(SAMPLES);

    typedef logic [WIDTH-1:0] sample_t;
    typedef sample_t frame_t [SAMPLES];

    // Reverses the low aw bits of idx; bits above aw are ignored.
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned aw);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < aw) begin
                r = (r << 1) | ((idx >> i) & 32'd1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_loader_if.sv
// rtl/fft_sample_loader_if.sv - sample-in / frame-out handshake bundle for the FFT loader
interface fft_sample_loader_if #(
    parameter int SAMPLES = fft_pkg::SAMPLES,
    parameter int WIDTH   = fft_pkg::WIDTH
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in_sample;
    logic                          flush;
    logic                          frame_valid;
    logic                          frame_ready;
    logic [SAMPLES-1:0][WIDTH-1:0] frame_out;
    logic [7:0]                    frame_count;

    modport master (
        output in_valid, in_sample, flush, frame_ready,
        input  in_ready, frame_valid, frame_out, frame_count
    );

    modport slave (
        input  in_valid, in_sample, flush, frame_ready,
        output in_ready, frame_valid, frame_out, frame_count
    );
endinterface

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one frame bank: single addressed write port, full parallel read
module fft_frame_bank #(
    parameter  int SAMPLES = 8,
    parameter  int WIDTH   = 4,
    localparam int ADDR_W  = $clog2(SAMPLES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [WIDTH-1:0]              wdata,
    output logic [SAMPLES-1:0][WIDTH-1:0] rdata
);

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (we) begin
            rdata[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// rtl/fft_sample_loader.sv - ping-pong frame loader writing samples at bit-reversed addresses
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int SAMPLES = fft_pkg::SAMPLES,
    parameter int WIDTH   = fft_pkg::WIDTH
) (
    input logic               clk,
    input logic               reset,
    fft_sample_loader_if.slave bus
);

    localparam int ADDR_W = $clog2(SAMPLES);

    logic [1:0]                    full;
    logic [1:0]                    full_next;
    logic                          wr_bank;
    logic                          rd_bank;
    logic [ADDR_W-1:0]             wr_cnt;
    logic [ADDR_W-1:0]             waddr;
    logic [7:0]                    frame_count;
    logic                          accept;
    logic                          handoff;
    logic                          last;
    logic [SAMPLES-1:0][WIDTH-1:0] bank_data [2];

    assign bus.in_ready    = !reset && !full[wr_bank];
    assign bus.frame_valid = !reset && full[rd_bank];
    assign bus.frame_out   = bank_data[rd_bank];
    assign bus.frame_count = frame_count;

    // flush wins over a same-cycle accept, so the sample is dropped.
    assign accept  = bus.in_valid && bus.in_ready && !bus.flush;
    assign handoff = bus.frame_valid && bus.frame_ready;
    assign last    = (wr_cnt == ADDR_W'(SAMPLES - 1));
    assign waddr   = ADDR_W'(bitrev(32'(wr_cnt), ADDR_W));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .SAMPLES (SAMPLES),
            .WIDTH   (WIDTH)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (accept && (wr_bank == 1'(b))),
            .waddr (waddr),
            .wdata (bus.in_sample),
            .rdata (bank_data[b])
        );
    end

    // Accept needs the write bank empty and hand-off needs the read bank
    // full, so the two updates always touch different bits.
    always_comb begin
        full_next = full;
        if (accept && last) begin
            full_next[wr_bank] = 1'b1;
        end
        if (handoff) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            frame_count <= 8'd0;
        end else begin
            full <= full_next;
            if (bus.flush) begin
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (handoff) begin
                rd_bank     <= ~rd_bank;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb/tb_fft_sample_loader.sv - scoreboard bench for fft_sample_loader (8x4 and 16x8 builds)
module tb_fft_sample_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_sample_loader_if #(.SAMPLES(8),  .WIDTH(4)) bus ();
    fft_sample_loader_if #(.SAMPLES(16), .WIDTH(8)) bus16 ();

    fft_sample_loader #(.SAMPLES(8), .WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fft_sample_loader #(.SAMPLES(16), .WIDTH(8)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    int checks = 0;
    int errors = 0;

    int          part_q [$];
    logic [31:0] exp_q  [$];
    logic [7:0]  cnt_exp = 8'd0;

    function automatic int rev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames are lists of accepted samples; a hand-off
    // delivers the oldest completed frame; at most two frames may wait.
    always @(negedge clk) begin
        if (reset) begin
            check(bus.in_ready == 1'b0, "rst_in_ready", bus.in_ready, 0);
            check(bus.frame_valid == 1'b0, "rst_frame_valid", bus.frame_valid, 0);
            part_q.delete();
            exp_q.delete();
            cnt_exp = 8'd0;
        end else begin
            bit          ir_exp;
            logic [31:0] f;
            ir_exp = (exp_q.size() < 2);
            check(bus.in_ready == ir_exp, "in_ready", bus.in_ready, ir_exp);
            check(bus.frame_valid == (exp_q.size() != 0), "frame_valid", bus.frame_valid, exp_q.size() != 0);
            check(bus.frame_count == cnt_exp, "frame_count", bus.frame_count, cnt_exp);
            if (exp_q.size() != 0) begin
                check(bus.frame_out == exp_q[0], "frame_out", bus.frame_out, exp_q[0]);
                if (bus.frame_ready) begin
                    void'(exp_q.pop_front());
                    cnt_exp = cnt_exp + 8'd1;
                end
            end
            if (bus.flush) begin
                part_q.delete();
            end else if (bus.in_valid && ir_exp) begin
                part_q.push_back(int'(bus.in_sample));
                if (part_q.size() == 8) begin
                    for (int j = 0; j < 8; j++) begin
                        f[j*4 +: 4] = 4'(part_q[rev(j, 3)]);
                    end
                    exp_q.push_back(f);
                    part_q.delete();
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [3:0] d, input bit fr, input bit fl);
        bus.in_valid    = v;
        bus.in_sample   = d;
        bus.frame_ready = fr;
        bus.flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input bit fr, output int waits);
        bit acc;
        bus.in_valid    = 1'b1;
        bus.in_sample   = d;
        bus.frame_ready = fr;
        bus.flush       = 1'b0;
        waits = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
            waits++;
        end
        check(1'b0, "send_timeout", waits, 0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int stalls;
        logic [3:0] t1 [8];
        t1 = '{4'h0, 4'h4, 4'h4, 4'hC, 4'h0, 4'h4, 4'h4, 4'h4};

        bus.in_valid = 0; bus.in_sample = 0; bus.flush = 0; bus.frame_ready = 0;
        bus16.in_valid = 0; bus16.in_sample = 0; bus16.flush = 0; bus16.frame_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed first frame and hand-off
        for (int i = 0; i < 8; i++) send(t1[i], 1'b1, w);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        check(bus.frame_valid == 1'b1, "t1_latency", bus.frame_valid, 1);
        check(bus.frame_out == 32'h4C444400, "t1_frame", bus.frame_out, 32'h4C444400);
        check(bus.frame_count == 8'd0, "t1_count_before", bus.frame_count, 0);
        @(negedge clk);
        check(bus.frame_count == 8'd1, "t1_count_after", bus.frame_count, 1);
        @(posedge clk);
        #1;

        // Both banks fill with frame_ready low, 17th sample stalls
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(4'($urandom), 1'b0, w);
            stalls += w;
        end
        check(stalls == 0, "t2_no_stall_fill", stalls, 0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b1, 1'b0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // Continuous stream of 24 samples with frame_ready high
        stalls = 0;
        for (int i = 0; i < 24; i++) begin
            send(4'($urandom), 1'b1, w);
            stalls += w;
        end
        check(stalls == 0, "t3_no_bubbles", stalls, 0);
        repeat (3) cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // Flush a partial frame
        for (int i = 0; i < 5; i++) send(4'hF, 1'b0, w);
        cyc(1'b1, 4'hE, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b0, w);
        @(negedge clk);
        check(bus.frame_out == 32'h84627351, "t4_flush_frame", bus.frame_out, 32'h84627351);
        @(posedge clk);
        #1;
        repeat (2) cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // Reset with one full frame pending and a partial one
        for (int i = 0; i < 14; i++) send(4'($urandom), 1'b0, w);
        reset = 1'b1;
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check(bus.frame_out == 32'h0, "t5_frame_zero", bus.frame_out, 0);
        check(bus.frame_count == 8'd0, "t5_count_zero", bus.frame_count, 0);
        check(bus.in_ready == 1'b1, "t5_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0);
        end
        repeat (4) cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // 16x8 build with a ramp
        for (int i = 0; i < 16; i++) begin
            bus16.in_valid  = 1'b1;
            bus16.in_sample = 8'(i);
            @(posedge clk);
            #1;
        end
        bus16.in_valid = 1'b0;
        @(negedge clk);
        check(bus16.frame_valid == 1'b1, "w16_valid", bus16.frame_valid, 1);
        for (int j = 0; j < 16; j++) begin
            check(int'(bus16.frame_out[j]) == rev(j, 4), "w16_elem", bus16.frame_out[j], rev(j, 4));
        end
        check(bus16.frame_out[1] == 8'd8, "w16_elem1", bus16.frame_out[1], 8);
        check(bus16.frame_out[3] == 8'd12, "w16_elem3", bus16.frame_out[3], 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Input stage of the FFT pipeline, directly upstream of the bit-reversal and butterfly stages.
- Accepts a serial stream of WIDTH-bit samples using a valid/ready handshake.
- Assembles SAMPLES-long frames in a ping-pong (two-bank) buffer, writing each sample to its bit-reversed address.
- Presents each complete frame as a parallel array that the butterfly stages consume directly, with its own valid/ready handshake.

Parameters:
- SAMPLES, 8, frame length in samples; must be a power of two, >= 2.
- WIDTH, 4, sample width in bits.
- ADDR_W, $clog2(SAMPLES), derived index width; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_sample carries a valid sample this cycle.
- in_ready  output  1  loader can accept a sample this cycle.
- in_sample  input  WIDTH  sample data, unsigned.
- flush  input  1  discard the partially filled frame in the write bank.
- frame_valid  output  1  frame_out holds a complete frame.
- frame_ready  input  1  downstream consumes the frame this cycle.
- frame_out  output  [WIDTH-1:0] x [SAMPLES-1:0]  frame in bit-reversed order: frame_out[j] = sample number bitrev(j) of the frame.
- frame_count  output  8  count of frames handed off; wraps modulo 256.

Behaviour:
- State:
  - two banks of SAMPLES x WIDTH registers;
  - full[1:0];
  - wr_bank, rd_bank (1 bit each);
  - wr_cnt (ADDR_W bits).
- Reset, while reset is high and on the first cycle after it:
  - wr_cnt=0, wr_bank=0, rd_bank=0, full=2'b00;
  - every bank entry=0, frame_count=0;
  - in_ready=0 and frame_valid=0 while reset is high.
- in_ready = !reset && !full[wr_bank]. It is combinational from state and never depends on in_valid.
- Accept happens when in_valid && in_ready:
  - bank[wr_bank][bitrev(wr_cnt)] <= in_sample;
  - wr_cnt increments.
- Frame complete happens on an accept with wr_cnt==SAMPLES-1:
  - wr_cnt wraps to 0;
  - full[wr_bank] <= 1;
  - wr_bank toggles.
- frame_valid = full[rd_bank].
- frame_out = bank[rd_bank], driven straight from registers. It is stable while frame_valid is high and not yet consumed.
- Hand-off happens when frame_valid && frame_ready:
  - full[rd_bank] <= 0;
  - rd_bank toggles;
  - frame_count increments.
  - The bank contents are not cleared.
- Latency: the last sample of a frame is accepted in cycle t, and frame_valid is high in cycle t+1. In-to-out latency is 1 cycle.
- Throughput: with frame_ready held high, one sample is accepted every cycle with no bubbles, because the banks alternate.
- Both banks full: in_ready=0 and input stalls. One cycle after a hand-off frees a bank, in_ready returns to 1.
- Simultaneous frame complete on bank A and hand-off of bank B in the same cycle: both updates take effect, with no conflict.
- Frame complete while the other bank is empty: frame_valid rises regardless of frame_ready.
- flush:
  - Sets wr_cnt=0 and discards the partial frame in the write bank; stale data is overwritten later.
  - Full banks, rd_bank, frame_valid and frame_count are unaffected.
  - If flush and an accept occur in the same cycle, flush wins and the sample is dropped. in_ready is unchanged by flush.
- Reset mid-frame: partial and full frames are discarded and all state returns to reset values.
- No arithmetic is performed. Data passes through bit-exact.

Decomposition:
- Shared package fft_pkg holds:
  - SAMPLES/WIDTH defaults;
  - typedef sample_t (logic [WIDTH-1:0]);
  - typedef frame_t (sample_t array [SAMPLES]);
  - function bitrev(idx, ADDR_W), also used by the bit-reversal stage and the benches.
- One sub-module is natural: fft_frame_bank. It is a single bank with write port, write address and parallel read, instantiated twice. Control stays in the top module.

Test Plan:
- Reset then stream 0,4,4,12,0,4,4,4 (hex 0,4,4,C,0,4,4,4) with frame_ready=1 -> one cycle after the 8th accept, frame_valid=1 and frame_out[0..7]=0,0,4,4,4,4,C,4; frame_count becomes 1 after the hand-off.
- frame_ready=0 and 16 samples streamed back-to-back -> both banks full and in_ready=0 from cycle 17; the 17th sample stalls; frame_out holds frame 0 unchanged; raising frame_ready for one cycle shows frame 1 next cycle, and in_ready=1 the cycle after the hand-off.
- Continuous stream of 24 samples with frame_ready=1 -> in_ready never drops; three frames are delivered; frame_count=3.
- Accept 5 samples, assert flush, then stream 8 samples 1..8 -> the delivered frame is bitrev-ordered 1,5,3,7,2,6,4,8; none of the first 5 samples appear.
- Assert reset after 6 samples, with one full frame pending -> frame_valid=0, in_ready=0 during reset; after reset, in_ready=1, frame_count=0, frame_out=all zeros.
- SAMPLES=16, WIDTH=8 build with ramp 0..15 -> frame_out[j]=bitrev4(j); frame_out[1]=8, frame_out[3]=12.
